// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback source handshakes and register-file write port
interface wb_arbiter_if #(parameter int DATA_WIDTH = 64);
  logic                  src0_valid_i;
  logic                  src0_ready_o;
  logic [4:0]            src0_rd_i;
  logic [DATA_WIDTH-1:0] src0_data_i;
  logic                  src1_valid_i;
  logic                  src1_ready_o;
  logic [4:0]            src1_rd_i;
  logic [DATA_WIDTH-1:0] src1_data_i;
  logic                  we_o;
  logic [31:0]           w_addr_o;
  logic [DATA_WIDTH-1:0] w_data_o;
  logic [3:0]            starve_cnt_o;
  modport slave (
    input  src0_valid_i, src0_rd_i, src0_data_i, src1_valid_i, src1_rd_i, src1_data_i,
    output src0_ready_o, src1_ready_o, we_o, w_addr_o, w_data_o, starve_cnt_o
  );
  modport master (
    output src0_valid_i, src0_rd_i, src0_data_i, src1_valid_i, src1_rd_i, src1_data_i,
    input  src0_ready_o, src1_ready_o, we_o, w_addr_o, w_data_o, starve_cnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source writeback arbiter, src1 priority with src0 starvation guard
module wb_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_arbiter_if.slave   bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  gnt0, gnt1;
  logic [4:0]            rd;
  logic [DATA_WIDTH-1:0] wd;
  always_comb begin
    gnt1   = !rst_i && bus.src1_valid_i && !(bus.src0_valid_i && cnt_q >= LIMIT);
    gnt0   = !rst_i && bus.src0_valid_i && !gnt1;
    rd     = gnt1 ? bus.src1_rd_i : bus.src0_rd_i;
    wd     = gnt1 ? bus.src1_data_i : bus.src0_data_i;
    // x0 transfers consume the slot but never reach the register file
    we_d   = (gnt0 || gnt1) && rd != 5'd0;
    addr_d = we_d ? rd : addr_q;
    data_d = we_d ? wd : data_q;
    cnt_d  = (bus.src0_valid_i && !gnt0) ? (cnt_q >= LIMIT ? LIMIT : cnt_q + 4'd1) : 4'd0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign bus.src0_ready_o = gnt0;
  assign bus.src1_ready_o = gnt1;
  assign bus.we_o         = we_q;
  assign bus.w_addr_o     = {27'b0, addr_q};
  assign bus.w_data_o     = data_q;
  assign bus.starve_cnt_o = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus random traffic against a behavioural model
module tb_wb_arbiter;
  localparam int DW  = 64;
  localparam int LIM = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_wait = 0;
  logic m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic a0, a1;
  wb_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // One cycle: check readies against the model, advance the model, check registered outputs.
  task automatic step(output logic acc0, output logic acc1);
    logic r0, r1;
    logic [4:0] rd;
    logic [DW-1:0] d;
    #1;
    r1 = !rst_i && bus.src1_valid_i && !(bus.src0_valid_i && m_wait >= LIM);
    r0 = !rst_i && bus.src0_valid_i && !r1;
    check("ready0", bus.src0_ready_o, r0);
    check("ready1", bus.src1_ready_o, r1);
    acc0 = r0;
    acc1 = r1;
    if (rst_i) begin
      m_we = 0; m_addr = 0; m_data = 0; m_wait = 0;
    end else begin
      rd = r1 ? bus.src1_rd_i : bus.src0_rd_i;
      d  = r1 ? bus.src1_data_i : bus.src0_data_i;
      m_we = (r0 || r1) && rd != 0;
      if (m_we) begin m_addr = 32'(rd); m_data = d; end
      m_wait = (bus.src0_valid_i && !r0) ? ((m_wait + 1 > LIM) ? LIM : m_wait + 1) : 0;
    end
    @(posedge clk_i);
    #1;
    check("we", bus.we_o, m_we);
    check("addr", bus.w_addr_o, m_addr);
    check("data", bus.w_data_o, m_data);
    check("starve", bus.starve_cnt_o, 64'(m_wait));
  endtask
  task automatic drive0(input logic v, input logic [4:0] rd, input logic [DW-1:0] d);
    bus.src0_valid_i = v; bus.src0_rd_i = rd; bus.src0_data_i = d;
  endtask
  task automatic drive1(input logic v, input logic [4:0] rd, input logic [DW-1:0] d);
    bus.src1_valid_i = v; bus.src1_rd_i = rd; bus.src1_data_i = d;
  endtask
  initial begin
    logic [4:0] r1;
    drive0(0, 0, 0);
    drive1(0, 0, 0);
    // reset then idle
    step(a0, a1);
    step(a0, a1);
    rst_i = 0;
    step(a0, a1);
    check("t1_we", bus.we_o, 0);
    check("t1_addr", bus.w_addr_o, 0);
    // single source
    drive0(1, 5, 64'hDEAD_BEEF);
    step(a0, a1);
    check("t2_acc", a0, 1);
    check("t2_we", bus.we_o, 1);
    check("t2_addr", bus.w_addr_o, 5);
    check("t2_data", bus.w_data_o, 64'hDEAD_BEEF);
    drive0(0, 0, 0);
    step(a0, a1);
    check("t2_we_low", bus.we_o, 0);
    // contention and forced src0 grant
    r1 = 2;
    drive0(1, 1, 64'h11);
    drive1(1, r1, {59'd0, r1} << 4);
    for (int i = 0; i < 9; i++) begin
      step(a0, a1);
      check("t3_we", bus.we_o, 1);
      if (i < 4) check("t3_cnt", bus.starve_cnt_o, 64'(i + 1));
      if (i == 4) begin
        check("t3_src0", bus.w_addr_o, 1);
        check("t3_cnt0", bus.starve_cnt_o, 0);
      end
      if (a0) drive0(0, 0, 0);
      if (a1) begin
        r1 = r1 + 5'd1;
        drive1(r1 <= 9, r1, {59'd0, r1} << 4);
      end
    end
    check("t3_last", bus.w_data_o, 64'h90);
    // x0 discard
    drive1(1, 0, 64'hFF);
    step(a0, a1);
    check("t4_acc", a1, 1);
    check("t4_we", bus.we_o, 0);
    check("t4_data", bus.w_data_o, 64'h90);
    // same-rd collision
    drive0(1, 7, 64'hA);
    drive1(1, 7, 64'hB);
    step(a0, a1);
    check("t5_b", bus.w_data_o, 64'hB);
    drive1(0, 0, 0);
    step(a0, a1);
    check("t5_a", bus.w_data_o, 64'hA);
    check("t5_addr", bus.w_addr_o, 7);
    // reset mid-stream with a pending starvation count
    drive0(1, 2, 64'h22);
    drive1(1, 4, 64'h44);
    step(a0, a1);
    step(a0, a1);
    check("t6_pre", bus.starve_cnt_o, 2);
    rst_i = 1;
    step(a0, a1);
    check("t6_we", bus.we_o, 0);
    check("t6_cnt", bus.starve_cnt_o, 0);
    rst_i = 0;
    drive1(0, 0, 0);
    drive0(1, 3, 64'h33);
    step(a0, a1);
    check("t6_we2", bus.we_o, 1);
    check("t6_addr", bus.w_addr_o, 3);
    check("t6_data", bus.w_data_o, 64'h33);
    drive0(0, 0, 0);
    // random traffic, sources hold their transfer until accepted
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 40) == 0);
      if (!bus.src0_valid_i || a0) drive0($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom});
      if (!bus.src1_valid_i || a1) drive1($urandom_range(0, 3) != 0, 5'($urandom), {$urandom, $urandom});
      step(a0, a1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
